count_ones_collector: RTL and testbench
=======================================

# count_ones_collector

Result-collection stage that sits directly downstream of the count-ones machine. It captures each popcount the counter produces, detected on the rising edge of its `rdy` level, into a small show-ahead FIFO. Results are drained through a valid/ready handshake, and the block keeps running statistics: accepted sample count, saturating sum, maximum, and a sticky overflow flag. Host logic reads results without having to sample the counter at the exact cycle `rdy` rises.

## Interface
- `DATA_SIZE`, default 8: width of the word being counted upstream; sets the count range.
- `CNT_SIZE`, default 4: width of `cnt_in`; must be ≥ $clog2(DATA_SIZE+1).
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `SUM_SIZE`, default 16: width of the running sum.
- `SMP_SIZE`, default 16: width of the sample counter.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_b` in 1: reset, asynchronous and active-low.
- `rdy_in` in 1: counter done level; a rising edge marks a new result.
- `cnt_in` in CNT_SIZE: counter result; valid whenever `rdy_in`=1.
- `clr` in 1: synchronous clear of FIFO, statistics and overflow.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out CNT_SIZE: head entry (show-ahead); holds the last head value when empty.
- `out_ready` in 1: consumer accepts head when `out_valid`=1.
- `level` out $clog2(DEPTH+1): current occupancy.
- `samples` out SMP_SIZE: number of accepted results; saturates at all-ones.
- `total` out SUM_SIZE: sum of accepted results; saturates at all-ones.
- `max_cnt` out CNT_SIZE: largest accepted result since reset/clear.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.

## Operation
- Edge detect: register `rdy_q` ← `rdy_in` every cycle. `capture` = `rdy_in` & ~`rdy_q`. Sampling `cnt_in` happens in that same cycle.
- A level `rdy_in` held high for many cycles yields exactly one capture. A new capture requires `rdy_in` to drop for ≥1 cycle.
- `pop` = `out_valid` & `out_ready`. `push` = `capture` & (`level` < DEPTH | `pop`).
- FIFO uses write/read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The occupancy counter `level` is incremented on push only, decremented on pop only, and unchanged on both or neither.
- Drop: `capture` while `level`==DEPTH and no `pop` discards the value and sets `overflow`=1. Statistics are not updated.
- Statistics update on push only:
  - `samples` += 1, saturating.
  - `total` += zero-extended `cnt_in`, saturating at 2^SUM_SIZE−1. There is no wrap.
  - `max_cnt` ← `cnt_in` if greater.
- `clr`=1 has priority: pointers, `level`, `samples`, `total`, `max_cnt` and `overflow` all go to 0. Any same-cycle capture and pop are ignored. `rdy_q` still updates normally, so a `rdy_in` rise coincident with `clr` is lost.

## Timing
- Reset (`rst_b`=0, immediate): `rdy_q`=0, `out_valid`=0, `out_data`=0, `level`=0, `samples`=0, `total`=0, `max_cnt`=0, `overflow`=0.
- Reset mid-operation discards FIFO contents and statistics.
- If `rdy_in` is already 1 when `rst_b` deasserts, a capture occurs on the first clock edge, because `rdy_q` resets to 0.
- Capture latency: `rdy_in` rises before edge N, so the value is written at edge N. `out_valid`, `out_data` and the statistics reflect it after edge N, one cycle of latency.
- Pop: head is removed at the edge where `out_valid`&`out_ready`. The next entry appears on `out_data` after that edge.
- Empty FIFO: `out_valid`=0, so no pop is possible. A push in this cycle becomes visible the next cycle; there is no combinational bypass.
- Full FIFO with capture and pop in the same cycle: both take effect, `level` stays DEPTH, and there is no overflow.
- All outputs are registered, or are decoded from registers only (`out_valid` = `level`!=0). There is no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold `rst_b`=0 for 2 cycles, then release with `rdy_in`=0. Required: all outputs 0, and `out_valid` stays 0 for 10 cycles.
- Single capture and level hold: `cnt_in`=5 with `rdy_in` raised and held high for 6 cycles, `out_ready`=0. Required: `level`=1, `out_data`=5, `samples`=1, `total`=5, `max_cnt`=5 one cycle after the rise, and no further captures.
- Fill and overflow: with `out_ready`=0, issue 5 separate `rdy_in` pulses carrying 1,2,3,4,8 (DEPTH=4). Required: `level`=4, `overflow`=1, `samples`=4, `total`=10, `max_cnt`=4. The drained order is 1,2,3,4.
- Full plus simultaneous pop: with the FIFO full of 1,2,3,4, pulse `rdy_in` with `cnt_in`=7 in the same cycle `out_ready`=1. Required: `level` stays 4, `overflow`=0, and the drain order is 2,3,4,7.
- Sweep against reference: drive `cnt_in`=$countones(i) for i=0..255 with continuous `out_ready`=1. Required: every popped value matches, `samples`=256, `total`=1024, `max_cnt`=8, `overflow`=0.
- Clear and saturation: set SUM_SIZE=4 and push 3 values of 8. Required: `total`=15 (saturated). Then assert `clr` coincident with a `rdy_in` rise. Required: all statistics and `level` are 0 next cycle, with no capture.

Source files
------------

// File: rtl/count_ones_collector.sv
// Result-collection stage for the count-ones machine: captures each popcount on the rdy rise
// into a show-ahead FIFO, drains it by valid/ready and keeps saturating running statistics.
module count_ones_collector #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned CNT_SIZE  = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SUM_SIZE  = 16,
    parameter int unsigned SMP_SIZE  = 16
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       rdy_in,
    input  logic [CNT_SIZE-1:0]        cnt_in,
    input  logic                       clr,
    output logic                       out_valid,
    output logic [CNT_SIZE-1:0]        out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [SMP_SIZE-1:0]        samples,
    output logic [SUM_SIZE-1:0]        total,
    output logic [CNT_SIZE-1:0]        max_cnt,
    output logic                       overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = ((SUM_SIZE > CNT_SIZE) ? SUM_SIZE : CNT_SIZE) + 1;
    localparam logic [SUM_SIZE-1:0] SUM_MAX = '1;

    // Elaboration-time sanity of the parameter set
    generate
        if (CNT_SIZE < $clog2(DATA_SIZE + 1)) begin : g_cnt_too_narrow
            $error("CNT_SIZE too small for DATA_SIZE");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic                rdy_q;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CNT_SIZE-1:0] mem [DEPTH];

    logic                capture;
    logic                pop;
    logic                push;
    logic                drop;
    logic [PW-1:0]       rd_ptr_nxt;
    logic [LW-1:0]       level_nxt;
    logic [CNT_SIZE-1:0] head_nxt;
    logic [AW-1:0]       sum_ext;
    logic [SUM_SIZE-1:0] total_nxt;
    logic [SMP_SIZE-1:0] samples_nxt;
    logic [CNT_SIZE-1:0] max_nxt;

    // Handshake decode, occupancy and next head/statistics
    always_comb begin
        capture     = rdy_in & ~rdy_q;
        pop         = out_valid & out_ready;
        push        = capture & ((level < LW'(DEPTH)) | pop);
        drop        = capture & ~push;
        rd_ptr_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
        level_nxt   = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
        // A push landing on the new head slot means the FIFO was otherwise empty
        head_nxt = out_data;
        if (level_nxt != LW'(0)) begin
            head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? cnt_in : mem[rd_ptr_nxt];
        end
        sum_ext     = AW'(total) + AW'(cnt_in);
        total_nxt   = (sum_ext > AW'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_SIZE-1:0];
        samples_nxt = (&samples) ? samples : samples + SMP_SIZE'(1);
        max_nxt     = (cnt_in > max_cnt) ? cnt_in : max_cnt;
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= cnt_in;
        end
    end

    // Control, head and statistics registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdy_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            samples   <= '0;
            total     <= '0;
            max_cnt   <= '0;
            overflow  <= 1'b0;
        end else begin
            rdy_q <= rdy_in;
            if (clr) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                out_valid <= 1'b0;
                samples   <= '0;
                total     <= '0;
                max_cnt   <= '0;
                overflow  <= 1'b0;
            end else begin
                rd_ptr    <= rd_ptr_nxt;
                level     <= level_nxt;
                out_valid <= (level_nxt != LW'(0));
                out_data  <= head_nxt;
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    samples <= samples_nxt;
                    total   <= total_nxt;
                    max_cnt <= max_nxt;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_ones_collector.sv
// Directed-vector bench for count_ones_collector: default instance plus a SUM_SIZE=4 instance.
module tb_count_ones_collector;

    logic       clk;
    logic       rst_b;
    logic       rdy_in;
    logic [3:0] cnt_in;
    logic       clr;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [2:0] level;
    logic [15:0] samples;
    logic [15:0] total;
    logic [3:0] max_cnt;
    logic       overflow;

    logic       s_rdy;
    logic [3:0] s_cnt;
    logic       s_clr;
    logic       s_ready;
    logic       s_valid;
    logic [3:0] s_data;
    logic [2:0] s_level;
    logic [15:0] s_samples;
    logic [3:0] s_total;
    logic [3:0] s_max;
    logic       s_ovf;

    int vectors;
    int miscompares;

    count_ones_collector dut (
        .clk(clk), .rst_b(rst_b), .rdy_in(rdy_in), .cnt_in(cnt_in), .clr(clr),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .samples(samples), .total(total), .max_cnt(max_cnt),
        .overflow(overflow)
    );

    count_ones_collector #(.SUM_SIZE(4)) dut_sat (
        .clk(clk), .rst_b(rst_b), .rdy_in(s_rdy), .cnt_in(s_cnt), .clr(s_clr),
        .out_valid(s_valid), .out_data(s_data), .out_ready(s_ready),
        .level(s_level), .samples(s_samples), .total(s_total), .max_cnt(s_max),
        .overflow(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        rdy_in = 1'b1;
        cnt_in = v;
        step();
        rdy_in = 1'b0;
        step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    function automatic logic [3:0] ref_popcount(input logic [7:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int b = 0; b < 8; b++) n = n + 4'(x[b]);
        return n;
    endfunction

    task automatic test_reset();
        rst_b = 1'b0;
        step();
        step();
        vectors++;
        if ({out_valid, out_data, level, samples, total, max_cnt, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%0b data=%0d level=%0d samples=%0d total=%0d max=%0d ovf=%0b, need all 0",
                     out_valid, out_data, level, samples, total, max_cnt, overflow);
        end
        rst_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_valid cycle %0d: got %0b, need 0", k, out_valid);
            end
        end
    endtask

    task automatic test_single_hold();
        rdy_in = 1'b1;
        cnt_in = 4'd5;
        step();
        vectors++;
        if (level !== 3'd1 || out_data !== 4'd5 || samples !== 16'd1 || total !== 16'd5 || max_cnt !== 4'd5) begin
            miscompares++;
            $display("FAIL single_capture: got level=%0d data=%0d samples=%0d total=%0d max=%0d, need 1 5 1 5 5",
                     level, out_data, samples, total, max_cnt);
        end
        for (int k = 0; k < 5; k++) step();
        vectors++;
        if (level !== 3'd1 || samples !== 16'd1) begin
            miscompares++;
            $display("FAIL level_hold: got level=%0d samples=%0d, need 1 1", level, samples);
        end
        rdy_in = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 4'd5) begin
            miscompares++;
            $display("FAIL empty_hold: got valid=%0b level=%0d data=%0d, need 0 0 5", out_valid, level, out_data);
        end
    endtask

    task automatic drain4(input string name, input logic [3:0] e0, input logic [3:0] e1,
                          input logic [3:0] e2, input logic [3:0] e3);
        logic [3:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp[k]) begin
                miscompares++;
                $display("FAIL %s[%0d]: got valid=%0b data=%0d, need 1 %0d", name, k, out_valid, out_data, exp[k]);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_empty: got valid=%0b level=%0d, need 0 0", name, out_valid, level);
        end
    endtask

    task automatic test_fill_overflow();
        do_clr();
        pulse(4'd1); pulse(4'd2); pulse(4'd3); pulse(4'd4); pulse(4'd8);
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b1 || samples !== 16'd4 || total !== 16'd10 || max_cnt !== 4'd4) begin
            miscompares++;
            $display("FAIL fill_overflow: got level=%0d ovf=%0b samples=%0d total=%0d max=%0d, need 4 1 4 10 4",
                     level, overflow, samples, total, max_cnt);
        end
        drain4("fill_drain", 4'd1, 4'd2, 4'd3, 4'd4);
    endtask

    task automatic test_full_pop();
        do_clr();
        pulse(4'd1); pulse(4'd2); pulse(4'd3); pulse(4'd4);
        rdy_in = 1'b1;
        cnt_in = 4'd7;
        out_ready = 1'b1;
        step();
        rdy_in = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b0 || out_data !== 4'd2 || samples !== 16'd5) begin
            miscompares++;
            $display("FAIL full_pop: got level=%0d ovf=%0b head=%0d samples=%0d, need 4 0 2 5",
                     level, overflow, out_data, samples);
        end
        drain4("full_pop_drain", 4'd2, 4'd3, 4'd4, 4'd7);
    endtask

    task automatic test_reset_rdy_high();
        rst_b = 1'b0;
        rdy_in = 1'b1;
        cnt_in = 4'd3;
        #1;
        vectors++;
        if (level !== 3'd0 || out_valid !== 1'b0 || samples !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: got level=%0d valid=%0b samples=%0d, need 0 0 0", level, out_valid, samples);
        end
        step();
        rst_b = 1'b1;
        step();
        rdy_in = 1'b0;
        vectors++;
        if (level !== 3'd1 || out_data !== 4'd3 || samples !== 16'd1) begin
            miscompares++;
            $display("FAIL rdy_high_release: got level=%0d data=%0d samples=%0d, need 1 3 1", level, out_data, samples);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] e;
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            e = ref_popcount(8'(i));
            rdy_in = 1'b1;
            cnt_in = e;
            step();
            rdy_in = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                miscompares++;
                $display("FAIL sweep[%0d]: got valid=%0b data=%0d, need 1 %0d", i, out_valid, out_data, e);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if (samples !== 16'd256 || total !== 16'd1024 || max_cnt !== 4'd8 || overflow !== 1'b0 || level !== 3'd0) begin
            miscompares++;
            $display("FAIL sweep_stats: got samples=%0d total=%0d max=%0d ovf=%0b level=%0d, need 256 1024 8 0 0",
                     samples, total, max_cnt, overflow, level);
        end
    endtask

    task automatic test_clear_saturation();
        logic [3:0] exp_tot [3];
        exp_tot[0] = 4'd8; exp_tot[1] = 4'd15; exp_tot[2] = 4'd15;
        s_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_rdy = 1'b1;
            s_cnt = 4'd8;
            step();
            s_rdy = 1'b0;
            step();
            vectors++;
            if (s_total !== exp_tot[k] || s_samples !== 16'(k + 1)) begin
                miscompares++;
                $display("FAIL sat_total[%0d]: got total=%0d samples=%0d, need %0d %0d",
                         k, s_total, s_samples, exp_tot[k], k + 1);
            end
        end
        s_clr = 1'b1;
        s_rdy = 1'b1;
        s_cnt = 4'd6;
        step();
        s_clr = 1'b0;
        vectors++;
        if (s_total !== 4'd0 || s_samples !== 16'd0 || s_max !== 4'd0 || s_level !== 3'd0 || s_valid !== 1'b0 || s_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_capture: got total=%0d samples=%0d max=%0d level=%0d valid=%0b ovf=%0b, need all 0",
                     s_total, s_samples, s_max, s_level, s_valid, s_ovf);
        end
        step();
        s_rdy = 1'b0;
        vectors++;
        if (s_level !== 3'd0 || s_samples !== 16'd0) begin
            miscompares++;
            $display("FAIL clr_rise_lost: got level=%0d samples=%0d, need 0 0", s_level, s_samples);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_b = 1'b0;
        rdy_in = 1'b0;
        cnt_in = 4'd0;
        clr = 1'b0;
        out_ready = 1'b0;
        s_rdy = 1'b0;
        s_cnt = 4'd0;
        s_clr = 1'b0;
        s_ready = 1'b0;
        test_reset();
        test_single_hold();
        test_fill_overflow();
        test_full_pop();
        test_reset_rdy_high();
        test_sweep();
        test_clear_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
